// File: rtl/mem_copy_pkg.sv
// Shared constants and FSM state type for the mem_copy_engine block-copy initiator.
package mem_copy_pkg;

  localparam int MEM_DATA_W = 64;
  localparam int MEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_if.sv
// Memory-side bus between the copy engine (master) and the 64-bit data memory (slave).
interface mem_copy_if
  import mem_copy_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
);

  logic [ADDR_W-1:0] mem_read_adr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data_out;
  logic [ADDR_W-1:0] mem_write_adr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    output mem_read_adr,
    output mem_rd,
    input  mem_data_out,
    output mem_write_adr,
    output mem_wr,
    output mem_data_in
  );

  modport slave (
    input  mem_read_adr,
    input  mem_rd,
    output mem_data_out,
    input  mem_write_adr,
    input  mem_wr,
    input  mem_data_in
  );

endinterface

// File: rtl/mem_copy_ctr.sv
// Loadable source/destination pointers (wrapping modulo 2^ADDR_W) and remaining-word count.
module mem_copy_ctr
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_load,
  input  logic [ADDR_W-1:0] dst_load,
  input  logic [ADDR_W:0]   len_load,
  input  logic              src_step,
  input  logic              dst_step,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] remaining;

  // Pointers use plain ADDR_W-bit adds so 2^ADDR_W-1 rolls over to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_load;
      dst_ptr   <= dst_load;
      remaining <= len_load;
    end else begin
      if (src_step) begin
        src_ptr <= src_ptr + PTR_ONE;
      end
      if (dst_step) begin
        dst_ptr   <= dst_ptr + PTR_ONE;
        remaining <= remaining - CNT_ONE;
      end
    end
  end

  // Zero-detect of the count after the current word's decrement.
  assign last = (remaining == CNT_ONE);

endmodule

// File: rtl/mem_copy_engine.sv
// Forward block-copy engine: alternating RD/WR cycles per word, one-cycle done pulse.
// Optional XOR checksum of written words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_adr,
  input  logic [ADDR_W-1:0] dst_adr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  mem_copy_if.master        mem
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  copy_state_t       state;
  copy_state_t       state_next;
  logic              load;
  logic              rd_step;
  logic              wr_step;
  logic              last;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [DATA_W-1:0] rd_word;

  assign rd_word = mem.mem_data_out;

  mem_copy_ctr #(
    .ADDR_W (ADDR_W)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .src_load (src_adr),
    .dst_load (dst_adr),
    .len_load (len),
    .src_step (rd_step),
    .dst_step (wr_step),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    rd_step    = 1'b0;
    wr_step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (len == '0) ? DONE : RD;
        end
      end
      RD: begin
        rd_step    = 1'b1;
        state_next = WR;
      end
      WR: begin
        wr_step    = 1'b1;
        state_next = last ? DONE : RD;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == RD) || (state == WR);
  assign done = (state == DONE);

  // Memory outputs are loaded one edge ahead from the next state, so they are
  // registered yet line up with the RD/WR cycles; mem_data_in doubles as the read buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_rd        <= 1'b0;
      mem.mem_wr        <= 1'b0;
      mem.mem_read_adr  <= '0;
      mem.mem_write_adr <= '0;
      mem.mem_data_in   <= '0;
    end else begin
      mem.mem_rd <= (state_next == RD);
      mem.mem_wr <= (state_next == WR);
      if (state_next == RD) begin
        mem.mem_read_adr <= (state == IDLE) ? src_adr : src_ptr;
      end
      if (state_next == WR) begin
        mem.mem_write_adr <= dst_ptr;
        mem.mem_data_in   <= rd_word;
      end
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (load) begin
      checksum <= '0;
    end else if (wr_step) begin
      checksum <= checksum ^ mem.mem_data_in;
    end
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural memory plus forward-copy reference model.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_adr;
  logic [AW-1:0] dst_adr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
  logic [DW-1:0] obs_csum_done;
  logic [DW-1:0] obs_csum_after;
`endif

  mem_copy_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

  mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .src_adr (src_adr),
    .dst_adr (dst_adr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .mem     (mem_bus)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory with combinational read and clocked write; pre_* lets the bench preload words.
  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_adr;
  logic [DW-1:0] pre_data;

  assign mem_bus.mem_data_out = mem_arr[mem_bus.mem_read_adr];

  always @(posedge clk) begin
    if (mem_bus.mem_wr) mem_arr[mem_bus.mem_write_adr] <= mem_bus.mem_data_in;
    else if (pre_we)    mem_arr[pre_adr] <= pre_data;
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_words[$];
  logic [DW-1:0] model_csum;
  int obs_done_edge, obs_done_cnt, obs_rd_cnt, obs_wr_cnt;
  int obs_strobe_err, obs_adr_err, obs_busy_err, obs_done_err;

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_adr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem_arr[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Spec-level model: word i is read from src+i then written to dst+i, in order.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l);
    logic [DW-1:0] w;
    exp_words.delete();
    model_csum = '0;
    for (int i = 0; i < int'(l); i++) begin
      w = ref_mem[(int'(s) + i) % DEPTH];
      exp_words.push_back(w);
      ref_mem[(int'(d) + i) % DEPTH] = w;
      model_csum ^= w;
    end
  endtask

  // Drives one copy and observes 2*len+4 cycles against the expected cycle-by-cycle picture.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                          input int restart_at);
    int  n2;
    logic exp_rd, exp_wr;
    n2 = 2 * int'(l);
    model_copy(s, d, l);
    obs_done_edge = -1; obs_done_cnt = 0; obs_rd_cnt = 0; obs_wr_cnt = 0;
    obs_strobe_err = 0; obs_adr_err = 0; obs_busy_err = 0; obs_done_err = 0;
    @(negedge clk);
    src_adr = s; dst_adr = d; len = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < n2 + 4; n++) begin
      @(negedge clk);
      exp_rd = (n < n2) && (n % 2 == 0);
      exp_wr = (n < n2) && (n % 2 == 1);
      if (mem_bus.mem_rd === 1'b1) obs_rd_cnt++;
      if (mem_bus.mem_wr === 1'b1) obs_wr_cnt++;
      if (mem_bus.mem_rd !== exp_rd || mem_bus.mem_wr !== exp_wr) obs_strobe_err++;
      if (exp_rd && mem_bus.mem_read_adr !== AW'((int'(s) + n / 2) % DEPTH)) obs_adr_err++;
      if (exp_wr && (mem_bus.mem_write_adr !== AW'((int'(d) + n / 2) % DEPTH) ||
                     mem_bus.mem_data_in !== exp_words[n / 2])) obs_adr_err++;
      if (busy !== (n < n2)) obs_busy_err++;
      if (done === 1'b1) begin
        obs_done_cnt++;
        obs_done_edge = n;
`ifdef MEM_COPY_CHECKSUM_EN
        obs_csum_done = checksum;
`endif
      end
      if (done !== (n == n2)) obs_done_err++;
      if (restart_at >= 0 && n == restart_at) begin
        start = 1'b1; src_adr = '0; dst_adr = AW'(12'h0C0); len = (AW+1)'(2);
      end
      if (n == restart_at + 1) start = 1'b0;
    end
    start = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
    obs_csum_after = checksum;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (mem_bus.mem_rd !== 1'b0 || mem_bus.mem_wr !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got rd=%b wr=%b expected 0 0", mem_bus.mem_rd, mem_bus.mem_wr);
    end
    checks++;
    if (mem_bus.mem_read_adr !== '0 || mem_bus.mem_write_adr !== '0 || mem_bus.mem_data_in !== '0) begin
      errors++; $display("[TB] FAIL reset_bus: got ra=%h wa=%h din=%h expected 0", mem_bus.mem_read_adr,
                         mem_bus.mem_write_adr, mem_bus.mem_data_in);
    end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++; $display("[TB] FAIL reset_checksum: got %h expected 0", checksum);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) poke(AW'(12'h100 + i), {$urandom, $urandom} ^ DW'(i));
    run_copy(AW'(12'h100), AW'(12'h200), (AW+1)'(4), -1);
    checks++;
    if (obs_done_edge != 8) begin
      errors++; $display("[TB] FAIL basic_done_edge: got %0d expected 8", obs_done_edge);
    end
    checks++;
    if (obs_rd_cnt != 4 || obs_wr_cnt != 4) begin
      errors++; $display("[TB] FAIL basic_strobe_count: got rd=%0d wr=%0d expected 4 4", obs_rd_cnt, obs_wr_cnt);
    end
    checks++;
    if (obs_strobe_err != 0 || obs_busy_err != 0 || obs_done_err != 0) begin
      errors++; $display("[TB] FAIL basic_sequence: got strobe=%0d busy=%0d done=%0d bad cycles expected 0",
                         obs_strobe_err, obs_busy_err, obs_done_err);
    end
    checks++;
    if (obs_adr_err != 0) begin
      errors++; $display("[TB] FAIL basic_addr_data: got %0d bad cycles expected 0", obs_adr_err);
    end
    checks++;
    if (mem_diffs() != 0) begin
      errors++; $display("[TB] FAIL basic_memory: got %0d differing words expected 0", mem_diffs());
    end
  endtask

  task automatic test_zero_len();
    run_copy(AW'(12'h050), AW'(12'h060), (AW+1)'(0), -1);
    checks++;
    if (obs_done_edge != 0 || obs_done_cnt != 1) begin
      errors++; $display("[TB] FAIL zero_done: got edge=%0d count=%0d expected 0 1", obs_done_edge, obs_done_cnt);
    end
    checks++;
    if (obs_rd_cnt != 0 || obs_wr_cnt != 0 || obs_busy_err != 0) begin
      errors++; $display("[TB] FAIL zero_quiet: got rd=%0d wr=%0d busy_err=%0d expected 0 0 0",
                         obs_rd_cnt, obs_wr_cnt, obs_busy_err);
    end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++;
    if (obs_csum_done !== '0) begin
      errors++; $display("[TB] FAIL zero_checksum: got %h expected 0", obs_csum_done);
    end
`endif
  endtask

  task automatic test_wrap();
    run_copy(AW'(12'h3FE), AW'(12'h010), (AW+1)'(4), -1);
    checks++;
    if (obs_adr_err != 0 || obs_strobe_err != 0) begin
      errors++; $display("[TB] FAIL wrap_addr: got adr_err=%0d strobe_err=%0d expected 0 0", obs_adr_err, obs_strobe_err);
    end
    checks++;
    if (mem_diffs() != 0 || obs_done_edge != 8) begin
      errors++; $display("[TB] FAIL wrap_result: got diffs=%0d done_edge=%0d expected 0 8", mem_diffs(), obs_done_edge);
    end
  endtask

  task automatic test_busy_start();
    logic [DW-1:0] orig;
    run_copy(AW'(12'h020), AW'(12'h080), (AW+1)'(5), 3);
    checks++;
    if (obs_done_cnt != 1 || obs_done_err != 0 || obs_busy_err != 0) begin
      errors++; $display("[TB] FAIL busy_start_ignored: got done_count=%0d done_err=%0d busy_err=%0d expected 1 0 0",
                         obs_done_cnt, obs_done_err, obs_busy_err);
    end
    checks++;
    if (mem_diffs() != 0 || obs_adr_err != 0) begin
      errors++; $display("[TB] FAIL busy_start_memory: got diffs=%0d adr_err=%0d expected 0 0", mem_diffs(), obs_adr_err);
    end
    orig = ref_mem[12'h040];
    run_copy(AW'(12'h040), AW'(12'h041), (AW+1)'(3), -1);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (mem_arr[12'h040 + i] !== orig) begin
        errors++; $display("[TB] FAIL overlap_word%0d: got %h expected %h", i, mem_arr[12'h040 + i], orig);
      end
    end
    run_copy(AW'(12'h070), AW'(12'h070), (AW+1)'(3), -1);
    checks++;
    if (mem_diffs() != 0 || obs_done_edge != 6) begin
      errors++; $display("[TB] FAIL same_adr: got diffs=%0d done_edge=%0d expected 0 6", mem_diffs(), obs_done_edge);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] s, d;
    logic [AW:0]   l;
    for (int k = 0; k < 7; k++) begin
      s = AW'($urandom_range(0, DEPTH - 1));
      d = AW'($urandom_range(0, DEPTH - 1));
      l = (k == 6) ? (AW+1)'(DEPTH) : (AW+1)'($urandom_range(0, 24));
      run_copy(s, d, l, -1);
      checks++;
      if (obs_done_edge != 2 * int'(l) || obs_done_cnt != 1) begin
        errors++; $display("[TB] FAIL random%0d_done: got edge=%0d count=%0d expected %0d 1",
                           k, obs_done_edge, obs_done_cnt, 2 * int'(l));
      end
      checks++;
      if (obs_strobe_err + obs_adr_err + obs_busy_err + obs_done_err != 0 || mem_diffs() != 0) begin
        errors++; $display("[TB] FAIL random%0d_copy: got seq_err=%0d diffs=%0d expected 0 0", k,
                           obs_strobe_err + obs_adr_err + obs_busy_err + obs_done_err, mem_diffs());
      end
`ifdef MEM_COPY_CHECKSUM_EN
      checks++;
      if (obs_csum_done !== model_csum || obs_csum_after !== model_csum) begin
        errors++; $display("[TB] FAIL random%0d_checksum: got %h/%h expected %h", k, obs_csum_done,
                           obs_csum_after, model_csum);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    int busy_seen = 0;
    @(negedge clk);
    src_adr = AW'(12'h180); dst_adr = AW'(12'h280); len = (AW+1)'(8); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ref_mem[12'h280] = ref_mem[12'h180];
    ref_mem[12'h281] = ref_mem[12'h181];
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mem_bus.mem_wr !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_pre_wr: got %b expected 1", mem_bus.mem_wr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_bus.mem_rd !== 1'b0 || mem_bus.mem_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_async: got rd=%b wr=%b busy=%b done=%b expected 0 0 0 0",
                         mem_bus.mem_rd, mem_bus.mem_wr, busy, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (done_seen != 0 || busy_seen != 0) begin
      errors++; $display("[TB] FAIL reset_mid_no_done: got done=%0d busy=%0d cycles expected 0 0", done_seen, busy_seen);
    end
    checks++;
    if (mem_diffs() != 0) begin
      errors++; $display("[TB] FAIL reset_mid_memory: got %0d differing words expected 0", mem_diffs());
    end
  endtask

`ifdef MEM_COPY_CHECKSUM_EN
  task automatic test_checksum();
    poke(AW'(12'h300), DW'(8'h0F));
    poke(AW'(12'h301), DW'(8'hF0));
    poke(AW'(12'h302), DW'(8'hFF));
    poke(AW'(12'h310), DW'(8'hA5));
    run_copy(AW'(12'h300), AW'(12'h320), (AW+1)'(3), -1);
    checks++;
    if (obs_csum_done !== '0 || obs_csum_after !== '0) begin
      errors++; $display("[TB] FAIL checksum_three: got %h/%h expected 0", obs_csum_done, obs_csum_after);
    end
    run_copy(AW'(12'h310), AW'(12'h330), (AW+1)'(1), -1);
    checks++;
    if (obs_csum_done !== DW'(8'hA5)) begin
      errors++; $display("[TB] FAIL checksum_single: got %h expected a5", obs_csum_done);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
    pre_we = 1'b0; pre_adr = '0; pre_data = '0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) poke(AW'(i), {$urandom, $urandom});
    test_basic();
    test_zero_len();
    test_wrap();
    test_busy_start();
    test_random();
    test_reset_mid();
`ifdef MEM_COPY_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
